// File: rtl/ins_cache_nway.sv
// ins_cache_nway: N-way set-associative instruction cache model with true-LRU replacement,
// next-level fill handshake, hit/miss/read statistics and a one-set-per-cycle clear sweep.
module ins_cache_nway #(
    parameter int ADDR_W     = 32,
    parameter int SETS       = 16384,
    parameter int WAYS       = 4,
    parameter int LINE_BYTES = 64,
    parameter int CNT_W      = 32
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  cmd_valid,
    output logic                                  cmd_ready,
    input  logic [3:0]                            n,
    input  logic [ADDR_W-1:0]                     add_in,
    output logic                                  fill_req,
    output logic [ADDR_W-$clog2(LINE_BYTES)-1:0]  fill_addr,
    input  logic                                  fill_ack,
    output logic                                  rsp_valid,
    output logic                                  rsp_hit,
    output logic [CNT_W-1:0]                      hit_cnt,
    output logic [CNT_W-1:0]                      miss_cnt,
    output logic [CNT_W-1:0]                      read_cnt
);
    localparam int IDX_W  = $clog2(SETS);
    localparam int AGE_W  = $clog2(WAYS);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int LINE_W = ADDR_W - OFF_W;
    localparam int TAG_W  = LINE_W - IDX_W;
    localparam logic [AGE_W-1:0] OLDEST = AGE_W'(WAYS - 1);

    typedef enum logic [1:0] {CLEAR, IDLE, FILL} state_t;
    state_t state, state_n;

    logic [WAYS-1:0]   valid_mem [SETS];
    logic [TAG_W-1:0]  tag_mem   [SETS][WAYS];
    logic [AGE_W-1:0]  age_mem   [SETS][WAYS];
    logic [IDX_W-1:0]  ptr, idx;
    logic [LINE_W-1:0] line;
    logic [TAG_W-1:0]  tag;
    logic [WAYS-1:0]   set_valid, hit_vec, used;
    logic [AGE_W-1:0]  set_age [WAYS];
    logic [AGE_W-1:0]  hit_way, victim, upd_way, free_age, thr;
    logic hit, accept, fetch, do_hit, do_miss, do_fill, do_inv, do_clr;

    always_comb begin
        cmd_ready = state == IDLE;
        fill_req  = state == FILL;
        line      = state == FILL ? fill_addr : add_in[ADDR_W-1:OFF_W];
        idx       = line[IDX_W-1:0];
        tag       = line[LINE_W-1:IDX_W];
        set_valid = valid_mem[idx];
        hit_vec   = '0;
        used      = '0;
        hit_way   = '0;
        victim    = '0;
        free_age  = OLDEST;
        for (int w = 0; w < WAYS; w++) begin
            set_age[w] = age_mem[idx][w];
            hit_vec[w] = set_valid[w] && tag_mem[idx][w] == tag;
            if (hit_vec[w]) hit_way = AGE_W'(w);
            if (set_valid[w]) used[age_mem[idx][w]] = 1'b1;
            if (set_valid[w] && age_mem[idx][w] == OLDEST) victim = AGE_W'(w);
        end
        // Lowest invalid way beats the LRU way; lowest age not held by a valid way seeds installs.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!set_valid[w]) victim = AGE_W'(w);
            if (!used[w]) free_age = AGE_W'(w);
        end
        hit     = |hit_vec;
        accept  = cmd_valid && cmd_ready;
        fetch   = accept && n == 4'd2;
        do_hit  = fetch && hit;
        do_miss = fetch && !hit;
        do_fill = state == FILL && fill_ack;
        do_inv  = accept && n == 4'd3;
        do_clr  = accept && n == 4'd8;
        upd_way = state == FILL ? victim : hit_way;
        thr     = (state == FILL && !set_valid[victim]) ? free_age : set_age[upd_way];
        state_n = do_clr ? CLEAR : do_miss ? FILL : do_fill ? IDLE :
                  (state == CLEAR && &ptr) ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLEAR;
            ptr       <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            read_cnt  <= '0;
            fill_addr <= '0;
            rsp_valid <= 1'b0;
            rsp_hit   <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= state == CLEAR ? ptr + 1'b1 : '0;
            rsp_valid <= do_hit || do_fill;
            rsp_hit   <= do_hit;
            hit_cnt   <= do_clr ? '0 : hit_cnt + CNT_W'(do_hit);
            miss_cnt  <= do_clr ? '0 : miss_cnt + CNT_W'(do_miss);
            read_cnt  <= do_clr ? '0 : read_cnt + CNT_W'(fetch);
            if (do_miss) fill_addr <= line;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                valid_mem[ptr] <= '0;
                for (int w = 0; w < WAYS; w++) age_mem[ptr][w] <= '0;
            end
            if (do_inv) valid_mem[idx] <= set_valid & ~hit_vec;
            if (do_hit || do_fill)
                for (int w = 0; w < WAYS; w++)
                    age_mem[idx][w] <= AGE_W'(w) == upd_way ? '0 :
                                       (set_valid[w] && set_age[w] < thr) ? set_age[w] + 1'b1 : set_age[w];
            if (do_fill) begin
                valid_mem[idx][victim] <= 1'b1;
                tag_mem[idx][victim]   <= tag;
            end
        end
    end
endmodule
